mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter BLOCK_SIZE, default `BLOCK_SIZE, bytes per block transfer.
REQ-002 Parameter DEPTH, default 1024, number of blocks stored; power of two.
REQ-003 Parameter LATENCY, default 4, busy cycles per request; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mem_ifh  cache_mem_if.mem_p  --  memory side of the cache/memory interface; signals below are named from the cache's view.
REQ-007 mem_ifh.req_valid  input  1  request present.
REQ-008 mem_ifh.write  input  1  1 = block write, 0 = block read.
REQ-009 mem_ifh.addr  input  `SYS_BUS_WIDTH-`LOG2_BLOCK_SIZE  block address.
REQ-010 mem_ifh.data_out  input  BLOCK_SIZE x 8  write block.
REQ-011 mem_ifh.cache_miss  input  1  miss indication from cache, statistics only.
REQ-012 mem_ifh.ready  output  1  memory able to accept a request or response valid.
REQ-013 mem_ifh.data_in  output  BLOCK_SIZE x 8  read block.
REQ-014 rd_count, wr_count, miss_count  output  32 each  saturating statistics.

Function
REQ-015 FSM states: IDLE, BUSY, RESP; ready SHALL be 1 in IDLE and RESP, 0 in BUSY.
REQ-016 IDLE: req_valid=1 SHALL latch addr, write, data_out, load the latency counter with LATENCY-1, and enter BUSY next cycle.
REQ-017 BUSY: the counter SHALL decrement each cycle; at 0 the block SHALL be accessed and the FSM SHALL enter RESP, so ready rises exactly LATENCY cycles after the accepting edge.
REQ-018 Read: data_in SHALL present storage[addr mod DEPTH] from RESP entry until the next read completes; it SHALL hold otherwise.
REQ-019 Write: storage[addr mod DEPTH] SHALL take the latched data_out on the BUSY-to-RESP edge; data_in SHALL be unchanged.
REQ-020 RESP: the FSM SHALL stay while req_valid=1, and SHALL return to IDLE in the first cycle req_valid=0. A held request SHALL never be re-executed.
REQ-021 Back-to-back: the request after RESP-to-IDLE SHALL be accepted in the IDLE cycle it appears, with no extra bubble.
REQ-022 Address bits above log2(DEPTH) SHALL be ignored (aliasing); no error is raised.
REQ-023 Inputs changing during BUSY SHALL be ignored.
REQ-024 rd_count or wr_count SHALL increment by 1 on each IDLE-to-BUSY acceptance, according to the latched write bit.
REQ-025 miss_count SHALL increment on each 0-to-1 transition of cache_miss.
REQ-026 All counters SHALL saturate at 32'hFFFF_FFFF.
REQ-027 Unwritten storage SHALL read as zero.

Reset
REQ-028 rst=1 SHALL force IDLE, ready=1, data_in=0, latency counter=0, all counters=0, and the cache_miss edge register=0, immediately, without waiting for clk.
REQ-029 Reset SHALL clear all storage contents to zero.
REQ-030 Reset during BUSY SHALL abort the request with no storage write.
REQ-031 After rst falls, a request SHALL be acceptable on the first posedge.

Structure
REQ-032 The mem_state_t enum, LATENCY width, and counter width SHALL live in the shared package cache_pkg beside the `BLOCK_SIZE/`SYS_BUS_WIDTH defines.
REQ-033 A single sub-module, sat_counter (32-bit, increment enable, saturating, async reset), SHALL be instantiated three times.
REQ-034 Storage SHALL be a plain register array inside mem_ctrl, with no vendor macro.

Verification
REQ-035 Write-then-read: write addr 0x10 with block 0xA5 repeated, then read 0x10 -> ready low 4 cycles per request; data_in all 0xA5; wr_count=1, rd_count=1.
REQ-036 Held req_valid: keep req_valid=1 for 6 cycles after RESP entry -> FSM stays in RESP; rd_count increments once.
REQ-037 Flush-then-load (cache pattern): write 0x3, drop req_valid for 1 cycle, read 0x3 -> second request accepted in the IDLE cycle; data_in equals the written block.
REQ-038 Aliasing: with DEPTH=1024, write 0x405 then read 0x005 -> read returns the 0x405 data.
REQ-039 Async reset mid-BUSY: assert rst between clock edges during a write -> ready=1 and counters=0 immediately; a later read of that address returns 0.
REQ-040 Statistics: pulse cache_miss 3 times, holding it high 2 cycles each -> miss_count=3. Preload wr_count to 32'hFFFF_FFFF via force and issue a write -> wr_count stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache/memory definitions: bus geometry defines, memory FSM state type,
// latency/statistics widths and the saturating-increment helper.
`ifndef CACHE_DEFINES_SVH
`define CACHE_DEFINES_SVH
`define BLOCK_SIZE 4
`define LOG2_BLOCK_SIZE 2
`define SYS_BUS_WIDTH 32
`endif

package cache_pkg;
   localparam int ADDR_W = `SYS_BUS_WIDTH - `LOG2_BLOCK_SIZE;
   localparam int LAT_W  = 8;
   localparam int CNT_W  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction
endpackage

// File: rtl/cache_mem_if.sv
// Cache/memory block-transfer interface; signal names follow the cache's view.
interface cache_mem_if #(
   parameter int BLOCK_SIZE = `BLOCK_SIZE
);
   logic                         req_valid;
   logic                         write;
   logic [cache_pkg::ADDR_W-1:0] addr;
   logic [BLOCK_SIZE*8-1:0]      data_out;
   logic                         cache_miss;
   logic                         ready;
   logic [BLOCK_SIZE*8-1:0]      data_in;

   modport mem_p (
      input  req_valid, write, addr, data_out, cache_miss,
      output ready, data_in
   );
endinterface

// File: rtl/sat_counter.sv
// 32-bit statistics counter that sticks at all-ones instead of wrapping.
module sat_counter
   import cache_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i) begin
         count_d = sat_inc(count_q);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/mem_ctrl.sv
// Fixed-latency block memory behind the cache: IDLE/BUSY/RESP handshake FSM,
// register-array storage, and read/write/miss statistics.
module mem_ctrl
   import cache_pkg::*;
#(
   parameter int BLOCK_SIZE = `BLOCK_SIZE,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 4
) (
   input  logic             clk,
   input  logic             rst,
   cache_mem_if.mem_p       mem_ifh,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int DATA_W = BLOCK_SIZE * 8;
   localparam int IDX_W  = $clog2(DEPTH);

   mem_state_t        state_q, state_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              miss_q;
   logic              accept_s, done_s;
   logic              unused_addr_s;
   logic [DATA_W-1:0] storage_q [DEPTH];

   // High address bits alias onto the same block by design.
   assign unused_addr_s = ^mem_ifh.addr[ADDR_W-1:IDX_W];

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      idx_d    = idx_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      accept_s = 1'b0;
      done_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_ifh.req_valid) begin
               accept_s = 1'b1;
               idx_d    = mem_ifh.addr[IDX_W-1:0];
               write_d  = mem_ifh.write;
               wdata_d  = mem_ifh.data_out;
               lat_d    = LAT_W'(LATENCY - 1);
               state_d  = BUSY;
            end else begin
               state_d  = IDLE;
            end
         end
         BUSY: begin
            if (lat_q == {LAT_W{1'b0}}) begin
               done_s  = 1'b1;
               state_d = RESP;
            end else begin
               lat_d   = lat_q - LAT_W'(1);
            end
         end
         RESP: begin
            // A held request parks here and is never replayed.
            if (mem_ifh.req_valid) begin
               state_d = RESP;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d != BUSY);
      rdata_d = (done_s && !write_q) ? storage_q[idx_q] : rdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lat_q   <= {LAT_W{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         write_q <= 1'b0;
         wdata_q <= {DATA_W{1'b0}};
         rdata_q <= {DATA_W{1'b0}};
         ready_q <= 1'b1;
         miss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         miss_q  <= mem_ifh.cache_miss;
      end
   end

   // Reset wipes the array, so an aborted write can never land.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            storage_q[i] <= {DATA_W{1'b0}};
         end
      end else if (done_s && write_q) begin
         storage_q[idx_q] <= wdata_q;
      end
   end

   assign mem_ifh.ready   = ready_q;
   assign mem_ifh.data_in = rdata_q;

   sat_counter u_rd_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .inc_i   (accept_s & ~mem_ifh.write),
      .count_o (rd_count)
   );

   sat_counter u_wr_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .inc_i   (accept_s & mem_ifh.write),
      .count_o (wr_count)
   );

   sat_counter u_miss_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .inc_i   (mem_ifh.cache_miss & ~miss_q),
      .count_o (miss_count)
   );
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: latency, read/write data, held requests,
// back-to-back, aliasing, async reset and saturating statistics.
module tb_mem_ctrl;
   import cache_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [CNT_W-1:0] rd_count, wr_count, miss_count;
   int               total  = 0;
   int               passed = 0;
   int               lat;
   int               bad;

   cache_mem_if ifc ();

   mem_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .mem_ifh    (ifc),
      .rd_count   (rd_count),
      .wr_count   (wr_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Present a request and return posedges from acceptance until ready rises;
   // inputs are scrambled during BUSY to show they are ignored.
   task automatic do_req(input logic w, input logic [29:0] a, input logic [31:0] d, output int l);
      ifc.req_valid = 1'b1;
      ifc.write     = w;
      ifc.addr      = a;
      ifc.data_out  = d;
      l = 0;
      @(posedge clk); #1;
      ifc.write    = ~w;
      ifc.addr     = ~a;
      ifc.data_out = ~d;
      while (ifc.ready !== 1'b1 && l < 20) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic drop();
      @(negedge clk);
      ifc.req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ifc.req_valid  = 1'b0;
      ifc.write      = 1'b0;
      ifc.addr       = 30'd0;
      ifc.data_out   = 32'd0;
      ifc.cache_miss = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset_ready", {31'd0, ifc.ready}, 32'd1);
      check("reset_data_in", ifc.data_in, 32'd0);
      check("reset_rd", rd_count, 32'd0);
      check("reset_wr", wr_count, 32'd0);
      check("reset_miss", miss_count, 32'd0);

      // Release reset and request on the very first edge.
      @(negedge clk);
      rst = 1'b0;
      do_req(1'b1, 30'h10, 32'hA5A5_A5A5, lat);
      check("wr10_latency", lat, 32'd4);
      drop();
      @(negedge clk);
      do_req(1'b0, 30'h10, 32'h0, lat);
      check("rd10_latency", lat, 32'd4);
      check("rd10_data", ifc.data_in, 32'hA5A5_A5A5);
      check("rd10_wr_count", wr_count, 32'd1);
      check("rd10_rd_count", rd_count, 32'd1);

      bad = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ifc.ready !== 1'b1) bad++;
      end
      check("held_ready_low_cycles", bad, 32'd0);
      check("held_rd_count", rd_count, 32'd1);
      check("held_wr_count", wr_count, 32'd1);
      drop();

      // Flush-then-load with a single idle cycle between requests.
      @(negedge clk);
      do_req(1'b1, 30'h3, 32'h1234_5678, lat);
      check("wr3_latency", lat, 32'd4);
      drop();
      @(negedge clk);
      do_req(1'b0, 30'h3, 32'h0, lat);
      check("rd3_no_bubble_latency", lat, 32'd4);
      check("rd3_data", ifc.data_in, 32'h1234_5678);
      drop();

      @(negedge clk);
      do_req(1'b1, 30'h405, 32'hCAFE_F00D, lat);
      check("wr405_data_in_held", ifc.data_in, 32'h1234_5678);
      drop();
      @(negedge clk);
      do_req(1'b0, 30'h005, 32'h0, lat);
      check("rd005_alias_data", ifc.data_in, 32'hCAFE_F00D);
      drop();
      @(negedge clk);
      do_req(1'b0, 30'h007, 32'h0, lat);
      check("rd007_unwritten", ifc.data_in, 32'd0);
      drop();
      check("totals_wr", wr_count, 32'd3);
      check("totals_rd", rd_count, 32'd4);

      for (int p = 0; p < 3; p++) begin
         @(negedge clk); ifc.cache_miss = 1'b1;
         @(negedge clk);
         @(negedge clk); ifc.cache_miss = 1'b0;
         @(negedge clk);
      end
      check("miss_count", miss_count, 32'd3);

      @(negedge clk);
      force dut.u_wr_cnt.count_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.u_wr_cnt.count_q;
      check("wr_preload", wr_count, 32'hFFFF_FFFF);
      @(negedge clk);
      do_req(1'b1, 30'h8, 32'h0BAD_BEEF, lat);
      check("wr_saturated", wr_count, 32'hFFFF_FFFF);
      check("rd_after_saturate", rd_count, 32'd4);
      drop();

      // Abort a write mid-BUSY with an asynchronous reset.
      @(negedge clk);
      ifc.req_valid = 1'b1;
      ifc.write     = 1'b1;
      ifc.addr      = 30'h20;
      ifc.data_out  = 32'h5555_5555;
      @(posedge clk); #1;
      check("abort_busy_ready", {31'd0, ifc.ready}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("abort_ready", {31'd0, ifc.ready}, 32'd1);
      check("abort_wr", wr_count, 32'd0);
      check("abort_rd", rd_count, 32'd0);
      check("abort_miss", miss_count, 32'd0);
      check("abort_data_in", ifc.data_in, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ifc.req_valid = 1'b0;
      @(negedge clk);
      do_req(1'b1, 30'h30, 32'h1111_1111, lat);
      drop();
      @(negedge clk);
      do_req(1'b0, 30'h30, 32'h0, lat);
      check("post_reset_rd30", ifc.data_in, 32'h1111_1111);
      drop();
      @(negedge clk);
      do_req(1'b0, 30'h20, 32'h0, lat);
      check("post_reset_rd20_aborted", ifc.data_in, 32'd0);
      drop();
      @(negedge clk);
      do_req(1'b0, 30'h10, 32'h0, lat);
      check("post_reset_rd10_cleared", ifc.data_in, 32'd0);
      drop();
      check("post_reset_rd_count", rd_count, 32'd3);
      check("post_reset_wr_count", wr_count, 32'd1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
